// File: rtl/fifo_stream_out.sv
// 1-cycle-latency FIFO read port to valid/ready stream, 2-entry skid buffer.
// Define FIFO_STREAM_OUT_STAT_EN to add the saturating xfer_cnt counter.
module fifo_stream_out #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    buf_lvl
`ifdef FIFO_STREAM_OUT_STAT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  logic          r_pend;
  logic [1:0]    r_lvl;
  logic          r_valid;
  logic [DW-1:0] r_b0;
  logic [DW-1:0] r_b1;

  logic          w_pop;
  logic [1:0]    w_occ;
  logic [DW-1:0] w_b0_nxt;
  logic [DW-1:0] w_b1_nxt;

  assign w_pop = r_valid & m_ready;
  // lvl + pend never exceeds 2, so this cannot wrap
  assign w_occ = r_lvl + {1'b0, r_pend} - {1'b0, w_pop};

  assign fifo_re = rst & ~clr & ~fifo_empty
                 & (w_occ < 2'd2);

  always_comb begin
    w_b0_nxt = r_b0;
    w_b1_nxt = r_b1;
    if (w_pop) begin
      w_b0_nxt = r_b1;
      if (r_pend) begin
        if (r_lvl == 2'd1) w_b0_nxt = fifo_dout;
        else               w_b1_nxt = fifo_dout;
      end
    end else if (r_pend) begin
      if (r_lvl == 2'd0) w_b0_nxt = fifo_dout;
      else               w_b1_nxt = fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend  <= 1'b0;
      r_lvl   <= 2'd0;
      r_valid <= 1'b0;
      r_b0    <= '0;
      r_b1    <= '0;
    end else if (clr) begin
      r_pend  <= 1'b0;
      r_lvl   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_pend  <= fifo_re;
      r_lvl   <= w_occ;
      r_valid <= (w_occ != 2'd0);
      r_b0    <= w_b0_nxt;
      r_b1    <= w_b1_nxt;
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_b0;
  assign buf_lvl = r_lvl;

`ifdef FIFO_STREAM_OUT_STAT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_xfer_cnt <= 16'd0;
    end else if (w_pop && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural
// 1-cycle-latency FIFO model driving the read port.
module tb_fifo_stream_out;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          fifo_empty;
  logic          fifo_re;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    buf_lvl;
`ifdef FIFO_STREAM_OUT_STAT_EN
  logic [15:0]   xfer_cnt;
`endif

  fifo_stream_out #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_lvl    (buf_lvl)
`ifdef FIFO_STREAM_OUT_STAT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:31];
  int  wr_p = 0;
  int  rd_p = 0;
  bit  inf  = 1'b0;

  assign fifo_empty = inf ? 1'b0 : (rd_p == wr_p);

  always @(posedge clk) begin
    if (fifo_re) begin
      if (inf) begin
        fifo_dout <= fifo_dout + 8'd1;
      end else begin
        fifo_dout <= mem[rd_p];
        rd_p      <= rd_p + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_p] = w;
    wr_p++;
  endtask

  logic [DW-1:0] e_re [6] = '{1, 1, 1, 0, 0, 0};
  logic [DW-1:0] e_v  [6] = '{0, 0, 1, 1, 1, 0};
  logic [DW-1:0] e_l  [6] = '{0, 0, 1, 1, 1, 0};
  logic [DW-1:0] e_d  [6] = '{0, 0, 8'h11, 8'h22, 8'h33, 0};
  logic [DW-1:0] a5   [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

  initial begin
    int n_re;
    int got;
    int gaps;
    rst = 1'b0;
    clr = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_lvl", buf_lvl, 0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    #1;
    chk("rst_re_blocked", fifo_re, 0);

    // three words, consumer always ready
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("seq3_re_c%0d", k), fifo_re, e_re[k]);
      chk($sformatf("seq3_v_c%0d", k), m_valid, e_v[k]);
      chk($sformatf("seq3_lvl_c%0d", k), buf_lvl, e_l[k]);
      if (e_v[k] != 0)
        chk($sformatf("seq3_d_c%0d", k), m_data, e_d[k]);
      @(negedge clk);
    end

    // FIFO empty throughout
    n_re = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (fifo_re) n_re++;
      @(negedge clk);
    end
    #1;
    chk("empty_re_cnt", n_re, 0);
    chk("empty_valid", m_valid, 0);
    chk("empty_lvl", buf_lvl, 0);
    @(negedge clk);

    // five words with stalled consumer, then drain
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(a5[k]);
    n_re = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (fifo_re) n_re++;
      @(negedge clk);
    end
    #1;
    chk("stall_re_cnt", n_re, 2);
    chk("stall_lvl", buf_lvl, 2);
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, 8'hA1);
    @(negedge clk);
    #1;
    chk("stall_data_hold", m_data, 8'hA1);
    chk("stall_re_hold", fifo_re, 0);
    @(negedge clk);
    m_ready = 1'b1;
    got = 0;
    gaps = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      #1;
      if (m_valid) begin
        chk($sformatf("drain_w%0d", got), m_data, a5[got]);
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      @(negedge clk);
    end
    chk("drain_count", got, 5);
    chk("drain_gaps", gaps, 0);

    // clr with one buffered word and one in flight
    m_ready = 1'b0;
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    repeat (2) @(negedge clk);
    #1;
    chk("clr_pre_lvl", buf_lvl, 1);
    chk("clr_pre_pend_re", fifo_re, 0);
    clr = 1'b1;
    #1;
    chk("clr_re_low", fifo_re, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_valid", m_valid, 0);
    chk("clr_lvl", buf_lvl, 0);
    chk("clr_re_resume", fifo_re, 1);
    @(negedge clk);
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      #1;
      if (m_valid) begin
        chk("clr_next_word", m_data, 8'hB3);
        got++;
      end
      @(negedge clk);
    end
    chk("clr_word_seen", got, 1);

    // reset while two words buffered
    m_ready = 1'b0;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    repeat (5) @(negedge clk);
    #1;
    chk("rst2_pre_lvl", buf_lvl, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_re_low", fifo_re, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_valid", m_valid, 0);
    chk("rst2_data", m_data, 0);
    chk("rst2_lvl", buf_lvl, 0);
    @(negedge clk);
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 2; c++) begin
      #1;
      if (m_valid) begin
        chk($sformatf("rst2_w%0d", got), m_data,
            got == 0 ? 8'hC3 : 8'hC4);
        got++;
      end
      @(negedge clk);
    end
    chk("rst2_count", got, 2);

`ifdef FIFO_STREAM_OUT_STAT_EN
    #1;
    chk("stat_after_rst", xfer_cnt, 2);
    @(negedge clk);
    inf = 1'b1;
    got = 0;
    for (int c = 0; c < 70000; c++) begin
      #1;
      if (m_valid && m_ready) got++;
      if (got == 32'h10003) break;
      @(negedge clk);
    end
    chk("stat_xfers", got, 32'h10003);
    @(negedge clk);
    m_ready = 1'b0;
    inf = 1'b0;
    #1;
    chk("stat_sat", xfer_cnt, 16'hFFFF);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("stat_clr", xfer_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 Parameter: DW, default 8, data width of FIFO word and stream payload.
REQ-002 Port: clk  input  1  rising-edge clock shared with upstream FIFO.
REQ-003 Port: rst  input  1  synchronous reset, active-low.
REQ-004 Port: clr  input  1  synchronous flush, active-high.
REQ-005 Port: fifo_empty  input  1  upstream FIFO empty flag (combinational, same clk).
REQ-006 Port: fifo_re  output  1  upstream FIFO read enable, one word per asserted cycle.
REQ-007 Port: fifo_dout  input  DW  upstream FIFO read data.
REQ-008 Port: m_valid  output  1  stream data valid, registered.
REQ-009 Port: m_ready  input  1  stream consumer ready.
REQ-010 Port: m_data  output  DW  stream payload, registered.
REQ-011 Port: buf_lvl  output  2  words held in internal buffer, 0..2.
REQ-012 Port (only with FIFO_STREAM_OUT_STAT_EN): xfer_cnt  output  16  accepted-transfer count.

Function
REQ-013 Block SHALL convert a 1-cycle-latency FIFO read port into a valid/ready stream with a 2-entry buffer.
REQ-014 fifo_dout SHALL be captured in the cycle after fifo_re was asserted (pend flag); no other cycle's fifo_dout is used.
REQ-015 A transfer SHALL occur in any cycle with m_valid=1 and m_ready=1; the head word is then popped.
REQ-016 fifo_re SHALL be combinational: rst & !clr & !fifo_empty & (buf_lvl + pend - pop) < 2, pop = m_valid & m_ready.
REQ-017 Buffer SHALL never exceed 2 words; a captured word SHALL never be dropped except by clr or reset.
REQ-018 Buffer SHALL be in-order: head = oldest word; m_data = head, m_valid = (buf_lvl != 0).
REQ-019 While m_valid=1 and m_ready=0, m_data SHALL remain stable and m_valid SHALL remain 1.
REQ-020 Simultaneous capture and pop SHALL leave buf_lvl unchanged and append the captured word behind the remaining one.
REQ-021 Latency: first word SHALL appear on m_valid 2 cycles after the cycle fifo_re is first asserted.
REQ-022 Throughput: with fifo_empty=0 and m_ready=1 continuously, m_valid SHALL stay 1 and one word SHALL transfer per cycle.
REQ-023 clr SHALL, at the next edge, set buf_lvl=0, m_valid=0, pend=0, discarding any in-flight word; fifo_re=0 during clr.
REQ-024 fifo_re SHALL never be asserted while fifo_empty=1.

Reset
REQ-025 On a clk edge with rst=0: m_valid=0, m_data=0, buf_lvl=0, pend=0; fifo_re=0 while rst=0.
REQ-026 Reset mid-transfer SHALL discard the in-flight and buffered words; first post-reset fifo_re no earlier than the cycle after rst returns high.
REQ-027 With FIFO_STREAM_OUT_STAT_EN, xfer_cnt SHALL reset to 0 on rst=0 and on clr.

Configuration
REQ-028 Macro FIFO_STREAM_OUT_STAT_EN defined: xfer_cnt port and a 16-bit counter incrementing on each transfer, saturating at 0xFFFF.
REQ-029 Macro FIFO_STREAM_OUT_STAT_EN undefined: no xfer_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-030 FIFO holds 0x11,0x22,0x33, m_ready=1 -> fifo_re cycles 0,1,2; m_data 0x11,0x22,0x33 on cycles 2,3,4, m_valid low at cycle 5.
REQ-031 FIFO holds 5 words, m_ready=0 -> exactly 2 fifo_re pulses, buf_lvl=2, m_data=first word stable; m_ready=1 afterwards -> all 5 words in order, no gaps after the first.
REQ-032 FIFO empty throughout -> fifo_re never asserted, m_valid=0, buf_lvl=0.
REQ-033 buf_lvl=1, pend=1, clr asserted -> next cycle m_valid=0, buf_lvl=0, in-flight word never output; fifo_re=0 during clr.
REQ-034 rst=0 pulsed while buf_lvl=2 -> next cycle m_valid=0, m_data=0, buf_lvl=0; streaming resumes correctly after release.
REQ-035 STAT_EN build, 0x10000 transfers followed by 3 more -> xfer_cnt=0xFFFF; clr -> xfer_cnt=0.
